// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/redirect controller: drives all fetch-stage control inputs,
// resolves BEQ/BNE in ID, and keeps saturating stall/flush counters.
module id_hazard_ctrl #(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inInstruction,
    input  logic [31:0]      inPostPc,
    input  logic [31:0]      inRsData,
    input  logic [31:0]      inRtData,
    input  logic             inID_EX_MemRead,
    input  logic             inID_EX_RegWrite,
    input  logic [4:0]       inID_EX_Dest,
    input  logic             inEX_MEM_MemRead,
    input  logic [4:0]       inEX_MEM_Dest,
    output logic             outPCWrite,
    output logic             outIF_IDWrite,
    output logic             outIF_Flush,
    output logic             outPCSrc,
    output logic             outJump,
    output logic [31:0]      outAddId,
    output logic             outBubble,
    output logic             outHalted,
    output logic [CNT_W-1:0] outStallCnt,
    output logic [CNT_W-1:0] outFlushCnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_isBranch;
    logic        w_isJump;
    logic        w_usesRt;
    logic        w_loadUse;
    logic        w_brDep;
    logic        w_brLoad;
    logic        w_stall;
    logic        w_taken;
    logic        w_cntStall;
    logic        w_cntFlush;

    assign w_op       = inInstruction[31:26];
    assign w_rs       = inInstruction[25:21];
    assign w_rt       = inInstruction[20:16];
    assign w_isBranch = (w_op == OP_BEQ) || (w_op == OP_BNE);
    assign w_isJump   = (w_op == OP_J) || (w_op == OP_JAL);
    assign w_usesRt   = (w_op == OP_RTYPE) || w_isBranch || (w_op == OP_SW);

    assign w_loadUse = inID_EX_MemRead && (inID_EX_Dest != 5'd0) &&
                       ((inID_EX_Dest == w_rs) || (w_usesRt && (inID_EX_Dest == w_rt)));
    assign w_brDep   = w_isBranch && inID_EX_RegWrite && (inID_EX_Dest != 5'd0) &&
                       ((inID_EX_Dest == w_rs) || (inID_EX_Dest == w_rt));
    assign w_brLoad  = w_isBranch && inEX_MEM_MemRead && (inEX_MEM_Dest != 5'd0) &&
                       ((inEX_MEM_Dest == w_rs) || (inEX_MEM_Dest == w_rt));
    assign w_stall   = w_loadUse || w_brDep || w_brLoad;

    assign w_taken = ((w_op == OP_BEQ) && (inRsData == inRtData)) ||
                     ((w_op == OP_BNE) && (inRsData != inRtData));

    assign outAddId = inPostPc + {{14{inInstruction[15]}}, inInstruction[15:0], 2'b00};

    always_comb begin
        outPCWrite    = 1'b0;
        outIF_IDWrite = 1'b0;
        outIF_Flush   = 1'b0;
        outPCSrc      = 1'b0;
        outJump       = 1'b0;
        outBubble     = 1'b0;
        outHalted     = 1'b0;
        w_next        = r_state;
        w_cntStall    = 1'b0;
        w_cntFlush    = 1'b0;
        if (!rst_n) begin
            outIF_Flush = 1'b1;
            outBubble   = 1'b1;
            w_next      = S_RUN;
        end else if (r_state == S_HALT) begin
            outBubble = 1'b1;
            outHalted = 1'b1;
        end else if (inInstruction == HALT_WORD) begin
            outBubble = 1'b1;
            w_next    = S_HALT;
        end else if (w_stall) begin
            // Redirects wait until the operands are safe to compare
            outBubble  = 1'b1;
            w_next     = S_STALL;
            w_cntStall = 1'b1;
        end else if (w_isJump) begin
            outJump       = 1'b1;
            outIF_Flush   = 1'b1;
            outPCWrite    = 1'b1;
            outIF_IDWrite = 1'b1;
            w_next        = S_RUN;
            w_cntFlush    = 1'b1;
        end else if (w_taken) begin
            outPCSrc      = 1'b1;
            outIF_Flush   = 1'b1;
            outPCWrite    = 1'b1;
            outIF_IDWrite = 1'b1;
            w_next        = S_RUN;
            w_cntFlush    = 1'b1;
        end else begin
            outPCWrite    = 1'b1;
            outIF_IDWrite = 1'b1;
            w_next        = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_cntStall && (r_stallCnt != {CNT_W{1'b1}}))
                r_stallCnt <= r_stallCnt + 1'b1;
            if (w_cntFlush && (r_flushCnt != {CNT_W{1'b1}}))
                r_flushCnt <= r_flushCnt + 1'b1;
        end
    end

    assign outStallCnt = r_stallCnt;
    assign outFlushCnt = r_flushCnt;

endmodule
